// File: rtl/btb_update_queue_pkg.sv
// btb_update_queue shared definitions.
// Defaults and the write-filter rule.
package btb_update_queue_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int ADDR_W_DEF = 32;

  // A resolved branch needs a BTB write when taken and
  // the BTB either missed or supplied the wrong target.
  function automatic logic needs_write(
    input logic taken,
    input logic hit,
    input logic tgt_eq
  );
    return taken && (!hit || !tgt_eq);
  endfunction

endpackage

// File: rtl/btb_update_queue_if.sv
// btb_update_queue port bundle.
// slave is the queue's view, master the environment's.
interface btb_update_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              resolve_valid_i;
  logic              resolve_ready_o;
  logic [ADDR_W-1:0] resolve_pc_i;
  logic              resolve_taken_i;
  logic [ADDR_W-1:0] resolve_target_i;
  logic              resolve_btb_hit_i;
  logic [ADDR_W-1:0] resolve_pred_target_i;
  logic              update_valid_o;
  logic              update_ready_i;
  logic [ADDR_W-1:0] update_pc_o;
  logic [ADDR_W-1:0] update_branch_target_o;
  logic [CW-1:0]     count_o;

  modport slave (
    input  resolve_valid_i,
    input  resolve_pc_i,
    input  resolve_taken_i,
    input  resolve_target_i,
    input  resolve_btb_hit_i,
    input  resolve_pred_target_i,
    input  update_ready_i,
    output resolve_ready_o,
    output update_valid_o,
    output update_pc_o,
    output update_branch_target_o,
    output count_o
  );

  modport master (
    output resolve_valid_i,
    output resolve_pc_i,
    output resolve_taken_i,
    output resolve_target_i,
    output resolve_btb_hit_i,
    output resolve_pred_target_i,
    output update_ready_i,
    input  resolve_ready_o,
    input  update_valid_o,
    input  update_pc_o,
    input  update_branch_target_o,
    input  count_o
  );

endinterface

// File: rtl/bpu_fifo_core.sv
// Storage ring for pending BTB updates.
// Exposes per-slot PC match and head select for coalescing.
module bpu_fifo_core #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:2] push_pc,
  input  logic [ADDR_W-1:2] push_tgt,
  input  logic              pop,
  input  logic [DEPTH-1:0]  coal_vec,
  input  logic [ADDR_W-1:2] coal_tgt,
  input  logic [ADDR_W-1:2] query_pc,
  output logic [DEPTH-1:0]  match_vec,
  output logic [DEPTH-1:0]  head_oh,
  output logic [ADDR_W-1:2] head_pc,
  output logic [ADDR_W-1:2] head_tgt,
  output logic [CW-1:0]     count
);

  typedef struct packed {
    logic [ADDR_W-1:2] pc;
    logic [ADDR_W-1:2] target;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   cnt;
  logic [DEPTH-1:0] valid;

  // Slot is live when its distance from head is below count.
  always_comb begin
    valid     = '0;
    match_vec = '0;
    head_oh   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i]     = {1'b0, PW'(i) - head} < cnt;
      match_vec[i] = valid[i] && (mem[i].pc == query_pc);
      head_oh[i]   = (PW'(i) == head);
    end
  end

  // Ring state: allocate at tail, retarget in place, drain head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{pc: push_pc, target: push_tgt};
        tail      <= tail + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++)
        if (coal_vec[i]) mem[i].target <= coal_tgt;
      if (pop) head <= head + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head_pc  = mem[head].pc;
  assign head_tgt = mem[head].target;
  assign count    = cnt;

endmodule

// File: rtl/btb_update_queue.sv
// BTB write-side queue: filters resolved branches,
// coalesces same-PC requests and drains one per cycle.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  btb_update_queue_if.slave q
);

  logic              accept;
  logic              tgt_eq;
  logic              req;
  logic              pop;
  logic              push;
  logic              any_match;
  logic              upd_valid;
  logic [DEPTH-1:0]  match_vec;
  logic [DEPTH-1:0]  head_oh;
  logic [DEPTH-1:0]  live_match;
  logic [DEPTH-1:0]  coal_vec;
  logic [ADDR_W-1:2] head_pc;
  logic [ADDR_W-1:2] head_tgt;
  logic [CW-1:0]     cnt;
  logic              unused_bits;

  assign q.resolve_ready_o = (cnt != CW'(DEPTH));
  assign upd_valid         = (cnt != '0);
  assign accept = q.resolve_valid_i && q.resolve_ready_o;
  assign pop    = upd_valid && q.update_ready_i;
  assign tgt_eq = q.resolve_pred_target_i[ADDR_W-1:2]
               == q.resolve_target_i[ADDR_W-1:2];

  // Filter, then coalesce unless the only match is leaving.
  always_comb begin
    req        = accept && needs_write(q.resolve_taken_i,
                                       q.resolve_btb_hit_i,
                                       tgt_eq);
    live_match = match_vec & ~(pop ? head_oh : '0);
    any_match  = |live_match;
    coal_vec   = (req && any_match) ? live_match : '0;
    push       = req && !any_match;
  end

  bpu_fifo_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_pc   (q.resolve_pc_i[ADDR_W-1:2]),
    .push_tgt  (q.resolve_target_i[ADDR_W-1:2]),
    .pop       (pop),
    .coal_vec  (coal_vec),
    .coal_tgt  (q.resolve_target_i[ADDR_W-1:2]),
    .query_pc  (q.resolve_pc_i[ADDR_W-1:2]),
    .match_vec (match_vec),
    .head_oh   (head_oh),
    .head_pc   (head_pc),
    .head_tgt  (head_tgt),
    .count     (cnt)
  );

  assign q.update_valid_o         = upd_valid;
  assign q.update_pc_o            = {head_pc, 2'b00};
  assign q.update_branch_target_o = {head_tgt, 2'b00};
  assign q.count_o                = cnt;

  assign unused_bits = ^{q.resolve_pc_i[1:0],
                         q.resolve_target_i[1:0],
                         q.resolve_pred_target_i[1:0]};

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue.
// Each row is checked before its clock edge, then clocked.
module tb_btb_update_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  btb_update_queue_if #(.ADDR_W(32), .DEPTH(4)) bus ();

  btb_update_queue #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        tk;
    bit        hit;
    bit [31:0] tgt;
    bit [31:0] pred;
    bit        ur;
    bit        ev;
    bit [31:0] epc;
    bit [31:0] etgt;
    int        ec;
    bit        err;
    bit        cd;
  } vec_t;

  vec_t tv [28];

  function automatic vec_t mk(
    bit v, bit [31:0] pc, bit tk, bit hit, bit [31:0] tgt,
    bit [31:0] pred, bit ur, bit ev, bit [31:0] epc,
    bit [31:0] etgt, int ec, bit err, bit cd);
    vec_t r;
    r.v = v; r.pc = pc; r.tk = tk; r.hit = hit; r.tgt = tgt;
    r.pred = pred; r.ur = ur; r.ev = ev; r.epc = epc;
    r.etgt = etgt; r.ec = ec; r.err = err; r.cd = cd;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, bit [31:0] pc, bit tk, bit hit,
                       bit [31:0] tgt, bit [31:0] pred, bit ur);
    bus.resolve_valid_i       = v;
    bus.resolve_pc_i          = pc;
    bus.resolve_taken_i       = tk;
    bus.resolve_btb_hit_i     = hit;
    bus.resolve_target_i      = tgt;
    bus.resolve_pred_target_i = pred;
    bus.update_ready_i        = ur;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_valid"}, 32'(bus.update_valid_o), 32'd0);
    chk({tag, "_pc"}, bus.update_pc_o, 32'd0);
    chk({tag, "_tgt"}, bus.update_branch_target_o, 32'd0);
    chk({tag, "_count"}, 32'(bus.count_o), 32'd0);
    chk({tag, "_ready"}, 32'(bus.resolve_ready_o), 32'd1);
  endtask

  localparam bit [31:0] B = 32'h1C00_0000;

  initial begin
    tv[0]  = mk(1, B+'h010, 1, 0, B+'h400, 0, 1, 0, 0, 0, 0, 1, 0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 1, 1, B+'h010, B+'h400, 1, 1, 1);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tv[3]  = mk(1, B+'h020, 1, 1, B+'h400, B+'h400, 1, 0, 0, 0, 0, 1, 0);
    tv[4]  = mk(1, B+'h030, 0, 0, B+'h500, 0, 1, 0, 0, 0, 0, 1, 0);
    tv[5]  = mk(1, B+'h040, 1, 1, B+'h400, B+'h403, 1, 0, 0, 0, 0, 1, 0);
    tv[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    tv[7]  = mk(1, B+'h100, 1, 0, B+'h1000, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[8]  = mk(1, B+'h104, 1, 0, B+'h2000, 0, 0, 1, B+'h100, B+'h1000, 1, 1, 1);
    tv[9]  = mk(1, B+'h108, 1, 0, B+'h3000, 0, 0, 1, B+'h100, B+'h1000, 2, 1, 1);
    tv[10] = mk(1, B+'h10C, 1, 0, B+'h4000, 0, 0, 1, B+'h100, B+'h1000, 3, 1, 1);
    tv[11] = mk(1, B+'h110, 1, 0, B+'h5000, 0, 0, 1, B+'h100, B+'h1000, 4, 0, 1);
    tv[12] = mk(1, B+'h110, 1, 0, B+'h5000, 0, 1, 1, B+'h100, B+'h1000, 4, 0, 1);
    tv[13] = mk(1, B+'h110, 1, 0, B+'h5000, 0, 1, 1, B+'h104, B+'h2000, 3, 1, 1);
    tv[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, B+'h108, B+'h3000, 3, 1, 1);
    tv[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, B+'h10C, B+'h4000, 2, 1, 1);
    tv[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, B+'h110, B+'h5000, 1, 1, 1);
    tv[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[18] = mk(1, B+'h200, 1, 0, B+'h8000, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[19] = mk(1, B+'h204, 1, 0, B+'h9000, 0, 0, 1, B+'h200, B+'h8000, 1, 1, 1);
    tv[20] = mk(1, B+'h202, 1, 0, B+'hA003, 0, 0, 1, B+'h200, B+'h8000, 2, 1, 1);
    tv[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, B+'h200, B+'hA000, 2, 1, 1);
    tv[22] = mk(0, 0, 0, 0, 0, 0, 1, 1, B+'h204, B+'h9000, 1, 1, 1);
    tv[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[24] = mk(1, B+'h300, 1, 0, B+'hB000, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[25] = mk(1, B+'h300, 1, 0, B+'hC000, 0, 1, 1, B+'h300, B+'hB000, 1, 1, 1);
    tv[26] = mk(0, 0, 0, 0, 0, 0, 1, 1, B+'h300, B+'hC000, 1, 1, 1);
    tv[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_reset_vals("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      drive(tv[i].v, tv[i].pc, tv[i].tk, tv[i].hit,
            tv[i].tgt, tv[i].pred, tv[i].ur);
      #3;
      chk($sformatf("row%0d_valid", i), 32'(bus.update_valid_o), 32'(tv[i].ev));
      chk($sformatf("row%0d_count", i), 32'(bus.count_o), 32'(tv[i].ec));
      chk($sformatf("row%0d_ready", i), 32'(bus.resolve_ready_o), 32'(tv[i].err));
      if (tv[i].cd) begin
        chk($sformatf("row%0d_pc", i), bus.update_pc_o, tv[i].epc);
        chk($sformatf("row%0d_tgt", i), bus.update_branch_target_o, tv[i].etgt);
      end
      @(posedge clk); #1;
    end

    for (int i = 0; i < 3; i++) begin
      drive(1, B + 32'h400 + 32'(i * 4), 1, 0, B + 32'hD000, 0, 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_count", 32'(bus.count_o), 32'd3);
    chk("pre_reset_valid", 32'(bus.update_valid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("after_release");

    drive(1, B + 32'h600, 1, 0, B + 32'hE000, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_count", 32'(bus.count_o), 32'd1);
    chk("post_reset_pc", bus.update_pc_o, B + 32'h600);
    chk("post_reset_tgt", bus.update_branch_target_o, B + 32'hE000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
